// File: rtl/vga_pkg.sv
// Shared timing defaults, colour width and receiver state encoding for the VGA receive path.
package vga_pkg;

  localparam int unsigned DEF_H_TOTAL     = 800;
  localparam int unsigned DEF_H_ACT_START = 144;
  localparam int unsigned DEF_H_ACTIVE    = 640;
  localparam int unsigned DEF_V_TOTAL     = 525;
  localparam int unsigned DEF_V_ACT_START = 35;
  localparam int unsigned DEF_V_ACTIVE    = 480;
  localparam int unsigned DEF_CW          = 11;

  localparam int unsigned RGB_W = 8;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/vga_edge_detect.sv
// Sample register with falling-edge detect; only an enabled cycle samples or reports an edge.
module vga_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic d_i,
  output logic fall_o
);

  logic prev_q;
  logic prev_d;

  // Reset to 0 so a line held low out of reset never reads as an edge.
  always_comb begin
    prev_d = prev_q;
    if (en_i) begin
      prev_d = d_i;
    end
  end

  assign fall_o = en_i & prev_q & ~d_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/vga_receiver.sv
// VGA sink: measures hsync/vsync raster timing, locks on a matching frame and
// emits registered active-area pixels with recovered x/y coordinates.
module vga_receiver
  import vga_pkg::*;
#(
  parameter int unsigned H_TOTAL     = DEF_H_TOTAL,
  parameter int unsigned H_ACT_START = DEF_H_ACT_START,
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned V_TOTAL     = DEF_V_TOTAL,
  parameter int unsigned V_ACT_START = DEF_V_ACT_START,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned CW          = DEF_CW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  input  logic             hsync,
  input  logic             vsync,
  input  logic [RGB_W-1:0] r_in,
  input  logic [RGB_W-1:0] g_in,
  input  logic [RGB_W-1:0] b_in,
  output logic [9:0]       x,
  output logic [9:0]       y,
  output logic             de,
  output logic             pix_valid,
  output logic [RGB_W-1:0] r_out,
  output logic [RGB_W-1:0] g_out,
  output logic [RGB_W-1:0] b_out,
  output logic             frame_start,
  output logic             locked,
  output logic             sync_err
);

  localparam int unsigned PixW = 3 * RGB_W;

  localparam logic [CW-1:0] HLast  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VLast  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HActLo = CW'(H_ACT_START);
  localparam logic [CW-1:0] HActHi = CW'(H_ACT_START + H_ACTIVE);
  localparam logic [CW-1:0] VActLo = CW'(V_ACT_START);
  localparam logic [CW-1:0] VActHi = CW'(V_ACT_START + V_ACTIVE);
  localparam logic [CW-1:0] CntMax = '1;

  // Sync edge detection
  logic line_start;
  logic frame_ev;

  vga_edge_detect u_hs_edge (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (pix_en),
    .d_i    (hsync),
    .fall_o (line_start)
  );

  // Sampled only at line starts, so a fall here means vsync went low between line starts.
  vga_edge_detect u_vs_edge (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (line_start),
    .d_i    (vsync),
    .fall_o (frame_ev)
  );

  // Sample stage: counters, FSM, captured colour
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   h_cnt_q, h_cnt_d;
  logic [CW-1:0]   v_cnt_q, v_cnt_d;
  logic            err_q, err_d;
  logic            pend_q, pend_d;
  logic [PixW-1:0] rgb_q, rgb_d;
  logic            fs_ev_q, fs_ev_d;
  logic            serr_ev_q, serr_ev_d;

  logic h_len_bad;
  logic v_len_bad;
  logic h_miss;
  logic v_miss;

  assign h_len_bad = line_start & (h_cnt_q != HLast);
  assign v_len_bad = frame_ev & (v_cnt_q != VLast);
  assign h_miss    = pix_en & ~line_start & (h_cnt_q == HLast);
  assign v_miss    = line_start & ~frame_ev & (v_cnt_q == VLast);

  always_comb begin
    h_cnt_d = h_cnt_q;
    if (line_start) begin
      h_cnt_d = '0;
    end else if (pix_en && (h_cnt_q != CntMax)) begin
      h_cnt_d = h_cnt_q + CW'(1);
    end

    v_cnt_d = v_cnt_q;
    if (frame_ev) begin
      v_cnt_d = '0;
    end else if (line_start && (v_cnt_q != CntMax)) begin
      v_cnt_d = v_cnt_q + CW'(1);
    end

    pend_d = pix_en;
    rgb_d  = rgb_q;
    if (pix_en) begin
      rgb_d = {r_in, g_in, b_in};
    end
  end

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    fs_ev_d   = 1'b0;
    serr_ev_d = 1'b0;

    unique case (state_q)
      SEARCH: begin
        if (frame_ev) begin
          state_d = MEASURE;
          err_d   = 1'b0;
        end
      end

      MEASURE: begin
        // The frame start that closes a measurement also closes its last line.
        if (frame_ev) begin
          if (!err_q && !h_len_bad && !v_len_bad) begin
            state_d = LOCKED;
            fs_ev_d = 1'b1;
          end else begin
            err_d = 1'b0;
          end
        end else if (h_len_bad) begin
          err_d = 1'b1;
        end
      end

      LOCKED: begin
        if (h_len_bad || v_len_bad || h_miss || v_miss) begin
          state_d   = SEARCH;
          serr_ev_d = 1'b1;
        end else if (frame_ev) begin
          fs_ev_d = 1'b1;
        end
      end

      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= SEARCH;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      err_q     <= 1'b0;
      pend_q    <= 1'b0;
      rgb_q     <= '0;
      fs_ev_q   <= 1'b0;
      serr_ev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      err_q     <= err_d;
      pend_q    <= pend_d;
      rgb_q     <= rgb_d;
      fs_ev_q   <= fs_ev_d;
      serr_ev_q <= serr_ev_d;
    end
  end

  // Output stage: one clk behind the sample, built from the post-sample counters and state
  logic            in_act;
  logic [9:0]      x_q, x_d;
  logic [9:0]      y_q, y_d;
  logic            de_q, de_d;
  logic [PixW-1:0] pix_q, pix_d;
  logic            pv_q, pv_d;
  logic            fs_q, fs_d;
  logic            locked_q, locked_d;
  logic            serr_q, serr_d;

  assign in_act = (state_q == LOCKED) &&
                  (h_cnt_q >= HActLo) && (h_cnt_q < HActHi) &&
                  (v_cnt_q >= VActLo) && (v_cnt_q < VActHi);

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    de_d  = de_q;
    pix_d = pix_q;
    if (pend_q) begin
      de_d  = in_act;
      x_d   = in_act ? 10'(h_cnt_q - HActLo) : '0;
      y_d   = in_act ? 10'(v_cnt_q - VActLo) : '0;
      pix_d = in_act ? rgb_q : '0;
    end
    pv_d     = pend_q;
    fs_d     = fs_ev_q;
    serr_d   = serr_ev_q;
    locked_d = (state_q == LOCKED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q      <= '0;
      y_q      <= '0;
      de_q     <= 1'b0;
      pix_q    <= '0;
      pv_q     <= 1'b0;
      fs_q     <= 1'b0;
      locked_q <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      de_q     <= de_d;
      pix_q    <= pix_d;
      pv_q     <= pv_d;
      fs_q     <= fs_d;
      locked_q <= locked_d;
      serr_q   <= serr_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign de          = de_q;
  assign r_out       = pix_q[3*RGB_W-1:2*RGB_W];
  assign g_out       = pix_q[2*RGB_W-1:RGB_W];
  assign b_out       = pix_q[RGB_W-1:0];
  assign pix_valid   = pv_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign sync_err    = serr_q;

endmodule

// File: tb/tb_vga_receiver.sv
// Bench for vga_receiver on a scaled-down 20x12 raster: lock acquisition, per-frame scenario
// table, pixel scoreboard and asynchronous reset.
module tb_vga_receiver;

  localparam int HT  = 20;
  localparam int HS  = 3;
  localparam int HAS = 5;
  localparam int HA  = 12;
  localparam int VT  = 12;
  localparam int VS  = 2;
  localparam int VAS = 3;
  localparam int VA  = 7;

  logic       clk;
  logic       reset;
  logic       pix_en;
  logic       hsync;
  logic       vsync;
  logic [7:0] r_in, g_in, b_in;
  logic [9:0] x, y;
  logic       de;
  logic       pix_valid;
  logic [7:0] r_out, g_out, b_out;
  logic       frame_start;
  logic       locked;
  logic       sync_err;

  vga_receiver #(
    .H_TOTAL     (HT),
    .H_ACT_START (HAS),
    .H_ACTIVE    (HA),
    .V_TOTAL     (VT),
    .V_ACT_START (VAS),
    .V_ACTIVE    (VA),
    .CW          (11)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pix_en      (pix_en),
    .hsync       (hsync),
    .vsync       (vsync),
    .r_in        (r_in),
    .g_in        (g_in),
    .b_in        (b_in),
    .x           (x),
    .y           (y),
    .de          (de),
    .pix_valid   (pix_valid),
    .r_out       (r_out),
    .g_out       (g_out),
    .b_out       (b_out),
    .frame_start (frame_start),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          h;
    int          v;
    logic [23:0] rgb;
  } exp_t;

  typedef struct {
    string name;
    int    n_lines;
    int    short_line;
    int    stuck_line;
    bit    gap;
    bit    chk;
    int    exp_de;
    int    exp_fs;
    int    exp_se;
    bit    exp_lk;
  } row_t;

  exp_t exp_q[$];
  exp_t mon_e;
  row_t rows[9];

  int n_tests = 0;
  int n_fail  = 0;
  int de_cnt, fs_cnt, se_cnt;
  int first_de_h, first_de_v;
  bit first_de_seen;
  bit gap;
  bit chk_en;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every pix_valid corresponds to the oldest strobe not yet reported.
  always @(negedge clk) begin
    logic        in_act;
    logic [44:0] act_v, exp_v;
    if (pix_valid) begin
      check("pv_has_strobe", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        if (chk_en) begin
          in_act = (mon_e.h >= HAS) && (mon_e.h < HAS + HA) &&
                   (mon_e.v >= VAS) && (mon_e.v < VAS + VA);
          exp_v  = in_act ? {1'b1, 10'(mon_e.h - HAS), 10'(mon_e.v - VAS), mon_e.rgb} : 45'd0;
          act_v  = {de, x, y, r_out, g_out, b_out};
          check($sformatf("pixel_h%0d_v%0d", mon_e.h, mon_e.v), 64'(act_v), 64'(exp_v));
        end
        if (de && !first_de_seen) begin
          first_de_seen = 1'b1;
          first_de_h    = mon_e.h;
          first_de_v    = mon_e.v;
        end
      end
      if (de) de_cnt++;
    end
    if (frame_start) fs_cnt++;
    if (sync_err) se_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_en = 1'b0;
    end
  endtask

  task automatic strobe(input logic hs, input logic vs, input int h, input int v);
    logic [7:0] r, g;
    r = 8'(h - HAS);
    g = 8'(v - VAS);
    @(negedge clk);
    pix_en = 1'b1;
    hsync  = hs;
    vsync  = vs;
    r_in   = r;
    g_in   = g;
    b_in   = 8'hA5;
    exp_q.push_back('{h: h, v: v, rgb: {r, g, 8'hA5}});
    if (gap) begin
      @(negedge clk);
      pix_en = 1'b0;
    end
  endtask

  // Generator: hsync low for h < HS from the line start, vsync low for v < VS.
  task automatic line(input int v, input int len, input bit stuck, input int h0);
    for (int h = h0; h < len; h++) begin
      strobe(stuck ? 1'b1 : (h >= HS), (v >= VS), h, v);
    end
  endtask

  task automatic frame(input int n_lines, input int short_line, input int stuck_line);
    for (int v = 0; v < n_lines; v++) begin
      line(v, (v == short_line) ? HT - 1 : HT, (v == stuck_line), 0);
    end
  endtask

  // Raster starts with both syncs low at the first sample after reset.
  task automatic acquire(input string tag);
    gap    = 1'b1;
    chk_en = 1'b0;
    fs_cnt = 0;
    frame(VT, -1, -1);
    idle(3);
    check({tag, "_no_lock_f1"}, 64'(locked), 64'd0);
    frame(VT, -1, -1);
    idle(3);
    check({tag, "_no_lock_f2"}, 64'(locked), 64'd0);
    check({tag, "_no_fs_pre_lock"}, 64'(fs_cnt), 64'd0);
    de_cnt        = 0;
    fs_cnt        = 0;
    first_de_seen = 1'b0;
    strobe(1'b0, 1'b0, 0, 0);
    check({tag, "_lock_not_early"}, 64'(locked), 64'd0);
    @(negedge clk);
    check({tag, "_lock_rise"}, 64'(locked), 64'd1);
    check({tag, "_fs_with_lock"}, 64'(frame_start), 64'd1);
    chk_en = 1'b1;
    line(0, HT, 1'b0, 1);
    for (int v = 1; v < VT; v++) begin
      line(v, HT, 1'b0, 0);
    end
    idle(3);
    chk_en = 1'b0;
    check({tag, "_de_count"}, 64'(de_cnt), 64'(HA * VA));
    check({tag, "_fs_count"}, 64'(fs_cnt), 64'd1);
    check({tag, "_first_de_h"}, 64'(first_de_h), 64'(HAS));
    check({tag, "_first_de_v"}, 64'(first_de_v), 64'(VAS));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, 64'(locked), 64'd0);
    check({tag, "_de"}, 64'(de), 64'd0);
    check({tag, "_flags"}, 64'({pix_valid, frame_start, sync_err}), 64'd0);
    check({tag, "_xyrgb"}, 64'({x, y, r_out, g_out, b_out}), 64'd0);
  endtask

  initial begin
    //            name          lines   short stuck gap chk de       fs se lk
    rows[0] = '{"clean_gap",    VT,     -1,   -1,   1,  1,  HA * VA, 1, 0, 1};
    rows[1] = '{"clean_b2b",    VT,     -1,   -1,   0,  1,  HA * VA, 1, 0, 1};
    rows[2] = '{"short_line",   VT,     5,    -1,   1,  0,  3 * HA,  1, 1, 0};
    rows[3] = '{"to_measure",   VT,     -1,   -1,   1,  0,  0,       0, 0, 0};
    rows[4] = '{"relock",       VT,     -1,   -1,   0,  1,  HA * VA, 1, 0, 1};
    rows[5] = '{"hs_stuck",     VT,     -1,   1,    1,  0,  0,       1, 1, 0};
    rows[6] = '{"meas_short",   VT - 1, -1,   -1,   1,  0,  0,       0, 0, 0};
    rows[7] = '{"meas_retry",   VT,     -1,   -1,   1,  0,  0,       0, 0, 0};
    rows[8] = '{"relock2",      VT,     -1,   -1,   1,  1,  HA * VA, 1, 0, 1};

    reset  = 1'b0;
    pix_en = 1'b0;
    hsync  = 1'b1;
    vsync  = 1'b1;
    r_in   = '0;
    g_in   = '0;
    b_in   = '0;
    gap    = 1'b1;
    chk_en = 1'b0;
    de_cnt = 0;
    fs_cnt = 0;
    se_cnt = 0;
    repeat (3) @(negedge clk);
    check_all_zero("init");
    reset = 1'b1;

    acquire("acq");

    for (int i = 0; i < 9; i++) begin
      gap    = rows[i].gap;
      chk_en = rows[i].chk;
      de_cnt = 0;
      fs_cnt = 0;
      se_cnt = 0;
      frame(rows[i].n_lines, rows[i].short_line, rows[i].stuck_line);
      idle(3);
      chk_en = 1'b0;
      check({rows[i].name, "_de"}, 64'(de_cnt), 64'(rows[i].exp_de));
      check({rows[i].name, "_fs"}, 64'(fs_cnt), 64'(rows[i].exp_fs));
      check({rows[i].name, "_se"}, 64'(se_cnt), 64'(rows[i].exp_se));
      check({rows[i].name, "_locked"}, 64'(locked), 64'(rows[i].exp_lk));
    end

    // Mid-line reset while locked and inside the active area.
    gap = 1'b1;
    for (int v = 0; v < 4; v++) begin
      line(v, HT, 1'b0, 0);
    end
    line(4, 10, 1'b0, 0);
    check("pre_rst_locked", 64'(locked), 64'd1);
    check("pre_rst_de", 64'(de), 64'd1);
    check("pre_rst_x", 64'(x), 64'd3);
    reset = 1'b0;
    #1;
    check_all_zero("mid_rst");
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;

    acquire("reacq");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
